apb_sram_slave: RTL and testbench
=================================

// Module: apb_sram_slave
// PURPOSE
//  Parametrised APB4 word-addressed SRAM slave for the RISC-V peripheral bus; successor
//  of the fixed 2 kB data memory. Adds configurable depth/base, PSTRB byte writes,
//  programmable wait states (PREADY stretching), and PSLVERR on out-of-window or
//  misaligned access. One outstanding transfer; sits behind the APB bridge decoder.
// PARAMETERS
//  DEPTH_WORDS  512        number of 32-bit words; power of 2, >=2
//  BASE_ADDR    32'h3000   byte base of window; aligned to DEPTH_WORDS*4
//  WAIT_STATES  0          PREADY-low cycles inserted in access phase (0..15)
// PORTS
//  PCLK     in   1   APB clock, all state on rising edge
//  PRESETn  in   1   asynchronous, active-low reset
//  PSEL     in   1   slave select
//  PENABLE  in   1   access phase
//  PWRITE   in   1   1=write, 0=read
//  PADDR    in   32  byte address
//  PWDATA   in   32  write data
//  PSTRB    in   4   write byte lanes, bit i -> PWDATA[8i+7:8i]
//  PRDATA   out  32  read data, valid when PREADY=1 on a read
//  PREADY   out  1   transfer completes on edge where PSEL&PENABLE&PREADY
//  PSLVERR  out  1   error response, valid only with PREADY=1
// BEHAVIOUR
//  - Reset values: wait_cnt=0, state=IDLE, PRDATA=0, err_q=0. Memory array NOT reset;
//    contents undefined until written. Reset is async assert, sync deassert upstream.
//  - In window: BASE_ADDR <= PADDR < BASE_ADDR+DEPTH_WORDS*4 (upper bound exclusive).
//    idx = (PADDR-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS). err = !in_window | PADDR[1:0]!=0.
//  - FSM: IDLE -> SETUP(PSEL&!PENABLE) -> ACCESS(PSEL&PENABLE) -> IDLE or SETUP.
//    Setup-phase edge: err_q<=err; PRDATA<= (read & !err) ? mem[idx] : 0; wait_cnt<=0.
//    ACCESS: wait_cnt increments each cycle while < WAIT_STATES, saturates.
//  - PREADY = (state==ACCESS) & (wait_cnt==WAIT_STATES); 0 in IDLE/SETUP.
//    WAIT_STATES=0 -> zero-wait transfer (2 PCLK total). Latency = 2+WAIT_STATES cycles.
//  - PSLVERR = PREADY & err_q; 0 otherwise.
//  - Write commits only on completion edge (PREADY=1) and only if !err_q: lanes with
//    PSTRB[i]=1 updated, others retained. PSTRB=4'b0000 -> no change, OKAY response.
//  - Reads ignore PSTRB. Error read returns PRDATA=0. Error write changes nothing.
//  - PRDATA returns to 0 on the edge after completion (not held across transfers).
//  - PSEL dropped in ACCESS before PREADY (protocol violation): abort to IDLE, no write,
//    wait_cnt=0.
//  - Back-to-back: completion edge with PSEL=1,PENABLE=0 next cycle enters SETUP directly.
//  - Write then read same address back-to-back returns new data (write lands before
//    next setup-edge capture).
//  - PRESETn asserted mid-transfer: FSM->IDLE, PREADY=0, PSLVERR=0, PRDATA=0 immediately;
//    a write not yet at completion edge is dropped.
// TESTING
//  1 WAIT_STATES=0: write 0xDEADBEEF @0x3000 PSTRB=F, read @0x3000 -> PRDATA=0xDEADBEEF,
//    PREADY=1 first access cycle, PSLVERR=0.
//  2 Byte lanes: pre-write 0x11223344 @0x3004, write 0xAABBCCDD PSTRB=4'b0101 ->
//    read 0x11BB33DD.
//  3 Errors: write @0x3800 (DEPTH 512) and @0x2FFC, and read @0x3002 -> PSLVERR=1,
//    PRDATA=0, memory @0x3000/0x37FC unchanged.
//  4 WAIT_STATES=3: any transfer -> PREADY low 3 access cycles, high on 4th; write
//    not visible before completion edge.
//  5 Back-to-back write 0x5A5A5A5A @0x37FC then immediate read @0x37FC -> 0x5A5A5A5A.
//  6 PRESETn pulse during WAIT_STATES=3 write access -> outputs 0 at once, location
//    keeps prior value, next transfer completes normally.

Source files
------------

// File: rtl/apb_sram_slave.sv
// APB4 word-addressed SRAM slave with byte strobes, PREADY wait states and PSLVERR.
// Latency: 2 + WAIT_STATES PCLK per transfer (setup cycle plus access cycles).
// Backpressure: PREADY is held low for WAIT_STATES access cycles; one transfer outstanding.
module apb_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    // Exclusive upper bound of the window, one bit wider so a window ending at
    // the top of the 32-bit space does not wrap to zero.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    // The register only needs to remember whether an access phase is in
    // progress; the setup cycle is recognised directly from PSEL & !PENABLE,
    // which also lets a completion edge flow straight into the next setup.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic [31:0] prdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]   addr_off;
    logic [AW-1:0] idx;
    logic          in_window;
    logic          addr_err;
    logic          setup_edge;
    logic          in_access;
    logic          pready;
    logic          complete;
    logic          mem_we;

    // Address decode: word index inside the window plus the error condition.
    always_comb begin
        addr_off  = PADDR - BASE_ADDR;
        idx       = AW'(addr_off >> 2);
        in_window = ({1'b0, PADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, PADDR} < WIN_END);
        addr_err  = !in_window || (PADDR[1:0] != 2'b00);
    end

    // Transfer phase qualifiers and the write strobe for the array.
    always_comb begin
        setup_edge = PSEL && !PENABLE;
        in_access  = (state_q == ST_ACCESS);
        pready     = in_access && (wait_cnt_q == WS);
        complete   = in_access && PSEL && PENABLE && pready;
        mem_we     = complete && PWRITE && !err_q;
    end

    // Transfer FSM: capture response at the setup edge, count wait states,
    // release on completion or abort.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            prdata_q   <= 32'h0;
            err_q      <= 1'b0;
        end else if (setup_edge) begin
            // Read data is fetched here so it is stable for the whole access
            // phase; a write completing on the previous edge is already in mem_q.
            state_q    <= ST_ACCESS;
            wait_cnt_q <= 4'd0;
            err_q      <= addr_err;
            prdata_q   <= (!PWRITE && !addr_err) ? mem_q[idx] : 32'h0;
        end else if (in_access) begin
            if (!PSEL) begin
                // Master abandoned the transfer before PREADY: drop it quietly.
                state_q    <= ST_IDLE;
                wait_cnt_q <= 4'd0;
                prdata_q   <= 32'h0;
            end else if (pready) begin
                // Completion edge: read data is not held into the next transfer.
                state_q    <= ST_IDLE;
                wait_cnt_q <= 4'd0;
                prdata_q   <= 32'h0;
            end else begin
                // Only reached while wait_cnt_q < WS, so the count saturates
                // at WS by construction.
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
        end
    end

    // Storage array: byte-lane writes on the completion edge only, no reset.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && PSTRB[i]) begin
                mem_q[idx][8*i +: 8] <= PWDATA[8*i +: 8];
            end
        end
    end

    assign PREADY  = pready;
    assign PSLVERR = pready && err_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Self-checking bench: zero-wait and three-wait instances of apb_sram_slave on a shared bus.
// Latency: each transfer is checked for exactly WAIT_STATES low-PREADY access cycles.
// Backpressure: every PREADY wait is bounded; an expired bound is a failed check.
module tb_apb_sram_slave;

    logic        PCLK;
    logic        PRESETn;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;

    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int passed = 0;
    int total  = 0;

    // Reference model: one 512-word image per instance, with a per-word flag
    // that says whether every byte of the word has been written.
    logic [31:0] mdl   [2][512];
    bit          known [2][512];

    apb_sram_slave #(.DEPTH_WORDS(512), .BASE_ADDR(32'h3000), .WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_sram_slave #(.DEPTH_WORDS(512), .BASE_ADDR(32'h3000), .WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? pready0 : pready3;
    endfunction

    function automatic logic slverr(input int inst);
        return (inst == 0) ? pslverr0 : pslverr3;
    endfunction

    function automatic logic [31:0] rdat(input int inst);
        return (inst == 0) ? prdata0 : prdata3;
    endfunction

    function automatic bit exp_err(input logic [31:0] addr);
        return (addr < 32'h3000) || (addr >= 32'h3000 + 512 * 4) || (addr % 4 != 0);
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr - 32'h3000) / 4);
    endfunction

    // Raw APB transfer. Entered and left at posedge+1 with nothing else on the
    // bus, so two calls in a row are back-to-back with no idle cycle.
    task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int waits);
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        PENABLE = 1'b0;
        psel0   = (inst == 0);
        psel3   = (inst != 0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK);
        while (!rdy(inst) && waits < 40) begin
            waits++;
            @(negedge PCLK);
        end
        chk("pready_seen", 32'(rdy(inst)), 32'd1);
        rd  = rdat(inst);
        err = slverr(inst);
        @(posedge PCLK); #1;
        PENABLE = 1'b0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        chk("prdata_cleared", rdat(inst), 32'h0);
        chk("pready_after", 32'(rdy(inst)), 32'd0);
    endtask

    // Transfer checked against the model; the model is updated for writes.
    task automatic do_xfer(input int inst, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           output logic [31:0] rd);
        logic e;
        int   w;
        bit   ee;
        int   k;
        ee = exp_err(addr);
        xfer(inst, wr, addr, data, strb, rd, e, w);
        chk("pslverr", 32'(e), 32'(ee));
        chk("wait_cycles", 32'(w), (inst == 0) ? 32'd0 : 32'd3);
        if (!wr) begin
            if (ee) chk("err_rdata", rd, 32'h0);
            else if (known[inst][widx(addr)]) chk("rdata", rd, mdl[inst][widx(addr)]);
        end else if (!ee) begin
            k = widx(addr);
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[inst][k][8*b +: 8] = data[8*b +: 8];
            if (strb == 4'hF) known[inst][k] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic        e;
        int          w;
        int          inst;

        PRESETn = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0;
        PWDATA  = 32'h0;
        PSTRB   = 4'h0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 512; j++) begin
                mdl[i][j]   = 32'h0;
                known[i][j] = 1'b0;
            end

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready0", 32'(pready0), 32'd0);
        chk("rst_pslverr0", 32'(pslverr0), 32'd0);
        chk("rst_prdata0", prdata0, 32'h0);
        chk("rst_pready3", 32'(pready3), 32'd0);
        chk("rst_prdata3", prdata3, 32'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write and read-back
        do_xfer(0, 1'b1, 32'h3000, 32'hDEADBEEF, 4'hF, rd);
        do_xfer(0, 1'b0, 32'h3000, 32'h0, 4'h0, rd);
        chk("t1_readback", rd, 32'hDEADBEEF);

        // Byte-lane merge and an empty-strobe write
        do_xfer(0, 1'b1, 32'h3004, 32'h11223344, 4'hF, rd);
        do_xfer(0, 1'b1, 32'h3004, 32'hAABBCCDD, 4'b0101, rd);
        do_xfer(0, 1'b0, 32'h3004, 32'h0, 4'hF, rd);
        chk("t2_lanes", rd, 32'h11BB33DD);
        do_xfer(0, 1'b1, 32'h3004, 32'hFFFFFFFF, 4'b0000, rd);
        do_xfer(0, 1'b0, 32'h3004, 32'h0, 4'h0, rd);
        chk("t2_nostrobe", rd, 32'h11BB33DD);

        // Out-of-window and misaligned accesses leave memory untouched
        do_xfer(0, 1'b1, 32'h37FC, 32'h01020304, 4'hF, rd);
        do_xfer(0, 1'b1, 32'h3800, 32'hCAFEF00D, 4'hF, rd);
        do_xfer(0, 1'b1, 32'h2FFC, 32'hCAFEF00D, 4'hF, rd);
        do_xfer(0, 1'b0, 32'h3002, 32'h0, 4'h0, rd);
        do_xfer(0, 1'b0, 32'h3000, 32'h0, 4'h0, rd);
        chk("t3_low_kept", rd, 32'hDEADBEEF);
        do_xfer(0, 1'b0, 32'h37FC, 32'h0, 4'h0, rd);
        chk("t3_high_kept", rd, 32'h01020304);

        // Back-to-back write then read at the top word
        do_xfer(0, 1'b1, 32'h37FC, 32'h5A5A5A5A, 4'hF, rd);
        do_xfer(0, 1'b0, 32'h37FC, 32'h0, 4'h0, rd);
        chk("t5_b2b", rd, 32'h5A5A5A5A);

        // Three wait states, including an error read
        @(posedge PCLK); #1;
        do_xfer(1, 1'b1, 32'h3010, 32'h12345678, 4'hF, rd);
        do_xfer(1, 1'b0, 32'h3010, 32'h0, 4'h0, rd);
        chk("t4_readback", rd, 32'h12345678);
        do_xfer(1, 1'b0, 32'h3801, 32'h0, 4'h0, rd);

        // Master drops PSEL during wait states: write must not land
        PWRITE = 1'b1; PADDR = 32'h3010; PWDATA = 32'hFFFF0000; PSTRB = 4'hF;
        PENABLE = 1'b0; psel3 = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        do_xfer(1, 1'b0, 32'h3010, 32'h0, 4'h0, rd);
        chk("abort_kept", rd, 32'h12345678);

        // Reset pulse in the completion cycle of a write
        do_xfer(1, 1'b1, 32'h3020, 32'h0BADF00D, 4'hF, rd);
        PWRITE = 1'b1; PADDR = 32'h3020; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        PENABLE = 1'b0; psel3 = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("t6_pre_ready", 32'(pready3), 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        chk("t6_pready", 32'(pready3), 32'd0);
        chk("t6_pslverr", 32'(pslverr3), 32'd0);
        chk("t6_prdata", prdata3, 32'h0);
        psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        do_xfer(1, 1'b0, 32'h3020, 32'h0, 4'h0, rd);
        chk("t6_kept", rd, 32'h0BADF00D);

        // Reset pulse while an error read is presenting PSLVERR
        PWRITE = 1'b0; PADDR = 32'h2000; PSTRB = 4'h0; PENABLE = 1'b0; psel3 = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("t6e_pre_err", 32'(pslverr3), 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        chk("t6e_pslverr", 32'(pslverr3), 32'd0);
        psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Randomised traffic against the model
        for (int n = 0; n < 80; n++) begin
            inst = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h3000 + 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(1, 3));
                    1:       a = 32'h3800 + 32'($urandom_range(0, 63)) * 4;
                    default: a = 32'h3000 - 32'($urandom_range(1, 64)) * 4;
                endcase
            end else if ($urandom_range(0, 1) == 0) begin
                a = 32'h3000 + 32'($urandom_range(0, 7)) * 4;
            end else begin
                a = 32'h3000 + 32'($urandom_range(504, 511)) * 4;
            end
            do_xfer(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        // Final confirmation that a plain transfer still completes after the traffic
        xfer(0, 1'b0, 32'h3000, 32'h0, 4'h0, rd, e, w);
        chk("final_err", 32'(e), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
